// File: rtl/bp_io_cmd_credit_mux.sv
// Round-robin multiplexer of IO command sources onto one io-noc command channel.
// It steers each command to a destination DID, keeps per-source credits and routes responses back by source id.
module bp_io_cmd_credit_mux #(
  parameter int num_src_p      = 4,
  parameter int cmd_width_p    = 128,
  parameter int resp_width_p   = 128,
  parameter int paddr_width_p  = 40,
  parameter int did_width_p    = 3,
  parameter int dev_offset_p   = 20,
  parameter int dev_width_p    = 4,
  parameter int boot_dev_p     = 0,
  parameter int host_dev_p     = 1,
  parameter int max_credits_p  = 4,
  parameter int src_id_width_p = (num_src_p > 1) ? $clog2(num_src_p) : 1
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [did_width_p-1:0]           my_did_i,
  input  logic [did_width_p-1:0]           host_did_i,
  input  logic [num_src_p*cmd_width_p-1:0] cmd_i,
  input  logic [num_src_p*paddr_width_p-1:0] cmd_addr_i,
  input  logic [num_src_p-1:0]             cmd_v_i,
  output logic [num_src_p-1:0]             cmd_yumi_o,
  output logic [cmd_width_p-1:0]           cmd_o,
  output logic [did_width_p-1:0]           cmd_dst_did_o,
  output logic [src_id_width_p-1:0]        cmd_src_id_o,
  output logic                             cmd_v_o,
  input  logic                             cmd_ready_i,
  input  logic [resp_width_p-1:0]          resp_i,
  input  logic [src_id_width_p-1:0]        resp_src_id_i,
  input  logic                             resp_v_i,
  output logic                             resp_yumi_o,
  output logic [resp_width_p-1:0]          resp_o,
  output logic [num_src_p-1:0]             resp_v_o,
  input  logic [num_src_p-1:0]             resp_ready_i,
  output logic [num_src_p-1:0]             credits_empty_o,
  output logic                             err_o
);

  localparam int cnt_width_lp = $clog2(max_credits_p + 1);

  logic [cnt_width_lp-1:0]   count_r [num_src_p];
  logic [src_id_width_p-1:0] ptr_r;
  logic [cmd_width_p-1:0]    cmd_r;
  logic [did_width_p-1:0]    dst_did_r;
  logic [src_id_width_p-1:0] src_id_r;
  logic                      cmd_v_r;
  logic                      err_r;

  logic [num_src_p-1:0]      elig_s;
  logic [num_src_p-1:0]      grant_s;
  logic [num_src_p-1:0]      yumi_s;
  logic                      grant_v_s;
  logic [src_id_width_p-1:0] grant_id_s;
  logic [src_id_width_p-1:0] next_ptr_s;
  logic                      space_s;
  logic [did_width_p-1:0]    addr_did_s;
  logic [dev_width_p-1:0]    addr_dev_s;
  logic [did_width_p-1:0]    dst_did_s;
  logic [cmd_width_p-1:0]    sel_cmd_s;
  logic                      id_ok_s;
  logic                      resp_yumi_s;
  logic [num_src_p-1:0]      resp_v_s;
  logic [num_src_p-1:0]      dec_s;
  logic                      zero_hit_s;
  logic                      err_set_s;
  int                        idx_s;

  // Round-robin search for the first eligible source, starting at the pointer.
  always_comb begin
    grant_s    = {num_src_p{1'b0}};
    grant_v_s  = 1'b0;
    grant_id_s = {src_id_width_p{1'b0}};
    idx_s      = 0;
    for (int i = 0; i < num_src_p; i++) begin
      elig_s[i] = cmd_v_i[i] & (count_r[i] < cnt_width_lp'(max_credits_p));
    end
    for (int k = 0; k < num_src_p; k++) begin
      idx_s = (int'(ptr_r) + k) % num_src_p;
      if (!grant_v_s && elig_s[idx_s]) begin
        grant_v_s         = 1'b1;
        grant_s[idx_s]    = 1'b1;
        grant_id_s        = src_id_width_p'(idx_s);
      end else begin
        grant_v_s = grant_v_s;
      end
    end
    if (grant_id_s == src_id_width_p'(num_src_p - 1)) begin
      next_ptr_s = {src_id_width_p{1'b0}};
    end else begin
      next_ptr_s = grant_id_s + src_id_width_p'(1);
    end
    space_s = ~cmd_v_r | cmd_ready_i;
    if (space_s && !reset_i) begin
      yumi_s = grant_s;
    end else begin
      yumi_s = {num_src_p{1'b0}};
    end
  end

  // Boot and host device windows of the local domain are redirected to the host.
  always_comb begin
    sel_cmd_s  = cmd_i[int'(grant_id_s)*cmd_width_p +: cmd_width_p];
    addr_did_s = cmd_addr_i[int'(grant_id_s)*paddr_width_p + paddr_width_p - did_width_p +: did_width_p];
    addr_dev_s = cmd_addr_i[int'(grant_id_s)*paddr_width_p + dev_offset_p +: dev_width_p];
    if (addr_did_s == {did_width_p{1'b0}}) begin
      if ((addr_dev_s == dev_width_p'(boot_dev_p)) || (addr_dev_s == dev_width_p'(host_dev_p))) begin
        dst_did_s = host_did_i;
      end else begin
        dst_did_s = my_did_i;
      end
    end else begin
      dst_did_s = addr_did_s;
    end
  end

  // Response demux; an out-of-range source id is consumed and dropped.
  always_comb begin
    id_ok_s    = (int'(resp_src_id_i) < num_src_p);
    zero_hit_s = 1'b0;
    if (id_ok_s) begin
      resp_yumi_s = resp_v_i & ~reset_i & resp_ready_i[resp_src_id_i];
    end else begin
      resp_yumi_s = resp_v_i & ~reset_i;
    end
    for (int s = 0; s < num_src_p; s++) begin
      resp_v_s[s] = resp_v_i & ~reset_i & (resp_src_id_i == src_id_width_p'(s));
      dec_s[s]    = resp_yumi_s & id_ok_s & (resp_src_id_i == src_id_width_p'(s));
      if (dec_s[s] && (count_r[s] == cnt_width_lp'(0))) begin
        zero_hit_s = 1'b1;
      end else begin
        zero_hit_s = zero_hit_s;
      end
      credits_empty_o[s] = (count_r[s] == cnt_width_lp'(0));
    end
    err_set_s = zero_hit_s | (resp_v_i & ~reset_i & ~id_ok_s);
  end

  // Credit counters: a same-cycle issue and return cancel; a return at zero never wraps.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int s = 0; s < num_src_p; s++) begin
        count_r[s] <= cnt_width_lp'(0);
      end
    end else begin
      for (int s = 0; s < num_src_p; s++) begin
        case ({yumi_s[s], dec_s[s]})
          2'b10: count_r[s] <= count_r[s] + cnt_width_lp'(1);
          2'b01: begin
            if (count_r[s] != cnt_width_lp'(0)) begin
              count_r[s] <= count_r[s] - cnt_width_lp'(1);
            end else begin
              count_r[s] <= count_r[s];
            end
          end
          default: count_r[s] <= count_r[s];
        endcase
      end
    end
  end

  // Output register, arbitration pointer and sticky error.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_r     <= {src_id_width_p{1'b0}};
      cmd_v_r   <= 1'b0;
      cmd_r     <= {cmd_width_p{1'b0}};
      dst_did_r <= {did_width_p{1'b0}};
      src_id_r  <= {src_id_width_p{1'b0}};
      err_r     <= 1'b0;
    end else begin
      err_r <= err_r | err_set_s;
      if (|yumi_s) begin
        ptr_r     <= next_ptr_s;
        cmd_v_r   <= 1'b1;
        cmd_r     <= sel_cmd_s;
        dst_did_r <= dst_did_s;
        src_id_r  <= grant_id_s;
      end else if (cmd_ready_i) begin
        cmd_v_r   <= 1'b0;
      end else begin
        cmd_v_r   <= cmd_v_r;
      end
    end
  end

  assign cmd_yumi_o    = yumi_s;
  assign cmd_o         = cmd_r;
  assign cmd_dst_did_o = dst_did_r;
  assign cmd_src_id_o  = src_id_r;
  assign cmd_v_o       = cmd_v_r;
  assign resp_yumi_o   = resp_yumi_s;
  assign resp_o        = resp_i;
  assign resp_v_o      = resp_v_s;
  assign err_o         = err_r;

endmodule

// File: doc/bp_io_cmd_credit_mux.md
Name: bp_io_cmd_credit_mux

Overview:
- Parametrised successor to the single-channel IO tile command path.
- Multiplexes num_src_p independent IO command sources onto one io-noc command channel using round-robin arbitration.
- Steers each command to a destination DID, redirecting boot/host device addresses to the host.
- Tracks outstanding requests per source with credit counters, and demultiplexes returning responses back to the originating source by source id.

Parameters:
- num_src_p, 4, number of command sources/channels.
- cmd_width_p, 128, opaque command payload width.
- resp_width_p, 128, opaque response payload width.
- paddr_width_p, 40, physical address width.
- did_width_p, 3, IO domain id width; the DID field is addr[paddr_width_p-1 -: did_width_p].
- dev_offset_p, 20, LSB position of the device field in a local address.
- dev_width_p, 4, device field width.
- boot_dev_p, 0, boot device number.
- host_dev_p, 1, host device number.
- max_credits_p, 4, maximum outstanding commands per source.
- src_id_width_p, `BSG_SAFE_CLOG2(num_src_p), width of the source tag.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- my_did_i  in  did_width_p  this tile's DID.
- host_did_i  in  did_width_p  host DID.
- cmd_i  in  num_src_p*cmd_width_p  per-source command payload.
- cmd_addr_i  in  num_src_p*paddr_width_p  per-source command address.
- cmd_v_i  in  num_src_p  per-source command valid.
- cmd_yumi_o  out  num_src_p  per-source command consumed.
- cmd_o  out  cmd_width_p  selected command payload.
- cmd_dst_did_o  out  did_width_p  destination DID.
- cmd_src_id_o  out  src_id_width_p  originating source tag.
- cmd_v_o  out  1  output command valid.
- cmd_ready_i  in  1  downstream ready.
- resp_i  in  resp_width_p  returning response payload.
- resp_src_id_i  in  src_id_width_p  response destination source.
- resp_v_i  in  1  response valid.
- resp_yumi_o  out  1  response consumed.
- resp_o  out  resp_width_p  response payload, broadcast to all sources.
- resp_v_o  out  num_src_p  one-hot per-source response valid.
- resp_ready_i  in  num_src_p  per-source ready.
- credits_empty_o  out  num_src_p  source i has zero outstanding commands.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset values:
  - cmd_v_o=0, cmd_yumi_o=0, resp_v_o=0, resp_yumi_o=0, err_o=0, credits_empty_o=all 1s.
  - Credit counters = 0; round-robin pointer = 0; output register payload = don't-care.
- Eligibility: source i is eligible when cmd_v_i[i]=1 and count[i] < max_credits_p.
- Arbitration: round-robin over eligible sources, starting at the pointer. On a grant to source g, the pointer becomes (g+1) mod num_src_p. The pointer is unchanged when there is no grant.
- Output register: a single-entry register holding cmd_o, cmd_dst_did_o, cmd_src_id_o and cmd_v_o.
  - space = ~cmd_v_o | cmd_ready_i.
  - cmd_yumi_o[g] = space & grant[g]. At most one bit is set per cycle.
  - Latency: command is on cmd_o the cycle after its yumi. Full throughput is one command per cycle under continuous cmd_ready_i.
- Output handshake:
  - On cmd_v_o & cmd_ready_i with no new grant, cmd_v_o clears next cycle.
  - While cmd_v_o=1 and cmd_ready_i=0, all outputs hold stable.
- Destination steering (for the address of granted source g, did = top field):
  - did==0 and dev ∈ {boot_dev_p, host_dev_p} → host_did_i.
  - did==0 otherwise → my_did_i.
  - did!=0 → did.
  - Steering is computed at grant time and registered.
- Credits:
  - count[g] increments on cmd_yumi_o[g].
  - count[s] decrements on resp_yumi_o with resp_src_id_i==s.
  - Simultaneous increment and decrement on the same source leaves the count unchanged.
  - Counter width is clog2(max_credits_p+1). The count never exceeds max_credits_p, because saturation blocks eligibility.
- Response demux:
  - resp_v_o[s] = resp_v_i & (resp_src_id_i==s).
  - resp_yumi_o = resp_v_i & resp_ready_i[resp_src_id_i].
  - The path is combinational: no buffering, zero latency.
- Error: set err_o when any of the following occurs; err_o clears only on reset.
  - A response is consumed for a source with count 0. The count stays 0 and does not wrap.
  - resp_src_id_i >= num_src_p while resp_v_i=1. The response is then consumed (yumi=1) and dropped.
- credits_empty_o[i] = (count[i]==0); used by fences.
- Reset mid-operation: all state returns to reset values on the next edge. In-flight output and counts are discarded.

Test Plan:
- Routing and latency: src0 issues addr with did=0, dev=1; host_did_i=5 → cycle+1: cmd_v_o=1, cmd_dst_did_o=5, cmd_src_id_o=0. Repeat with dev=3, my_did_i=2 → dst=2. Repeat with did=6 → dst=6.
- Round-robin and throughput: all 4 sources valid continuously, cmd_ready_i=1 → grants in order 0,1,2,3,0,… with one command per cycle. No source granted twice before all others are granted.
- Credit saturation: src1 issues 4 commands with no responses → 5th command is never yumi'd while the other sources keep flowing. One response with src_id=1 → src1 is granted the following cycle.
- Simultaneous issue/return: src2 at count=2 gets a yumi and a response in the same cycle → count stays 2. credits_empty_o[2] goes to 1 only after 2 further responses with no new issues.
- Backpressure: cmd_ready_i=0 for 5 cycles with cmd_v_o=1 → outputs stable and no cmd_yumi_o asserted. After ready returns, commands drain in order with no loss or duplication.
- Error and reset: response for src3 at count 0 → resp_yumi_o=1 and err_o=1 (sticky). Assert reset_i mid-burst → next cycle err_o=0, cmd_v_o=0, all credits_empty_o=1.
